// File: rtl/jk_ctrl_pkg.sv
// rtl/jk_ctrl_pkg.sv - command/state types and command-to-J/K decode for jk_bank_ctrl
package jk_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_HOLD   = 3'd0,
    CMD_CLR    = 3'd1,
    CMD_SET    = 3'd2,
    CMD_TOGGLE = 3'd3,
    CMD_PULSE  = 3'd4
  } cmd_e;

  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_PULSE_HOLD = 1'b1
  } state_e;

  // {J,K} pairs
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_CLR    = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // PULSE and the reserved codes decode to HOLD; the pulse FSM overrides this when built in.
  function automatic logic [1:0] jk_decode(input logic [2:0] cmd);
    logic [1:0] jk;
    case (cmd)
      CMD_CLR:    jk = JK_CLR;
      CMD_SET:    jk = JK_SET;
      CMD_TOGGLE: jk = JK_TOGGLE;
      default:    jk = JK_HOLD;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with enable and async active-high reset
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= 1'b0;
    end else if (en) begin
      case ({j, k})
        2'b01:   q_q <= 1'b0;
        2'b10:   q_q <= 1'b1;
        2'b11:   q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// rtl/jk_bank_ctrl.sv - two-requester round-robin controller for a bank of JK cells
// PULSE command and its hold FSM are built only when JK_BANK_CTRL_PULSE_EN is defined.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [2:0]       req0_cmd,
  input  logic [WIDTH-1:0] req0_mask,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_cmd,
  input  logic [WIDTH-1:0] req1_mask,
  output logic             req1_ready,
  input  logic [CNT_W-1:0] pulse_len,
  output logic [WIDTH-1:0] q,
  output logic             busy
);

  logic             idle;
  logic             ptr_q;   // last requester granted
  logic             gnt0, gnt1, xfer;
  logic [2:0]       cmd_sel;
  logic [WIDTH-1:0] mask_sel;
  logic [WIDTH-1:0] en_vec;
  logic             j_d, k_d;

`ifdef JK_BANK_CTRL_PULSE_EN
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mask_q;
  logic             busy_q;

  assign idle = (state_q == ST_IDLE);
  assign busy = busy_q;
`else
  logic unused_pulse_len;

  assign unused_pulse_len = ^pulse_len;
  assign idle = 1'b1;
  assign busy = 1'b0;
`endif

  assign gnt0 = !reset && idle && req0_valid && (!req1_valid || ptr_q);
  assign gnt1 = !reset && idle && req1_valid && (!req0_valid || !ptr_q);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer = gnt0 || gnt1;
  assign cmd_sel  = gnt1 ? req1_cmd  : req0_cmd;
  assign mask_sel = gnt1 ? req1_mask : req0_mask;

  always_comb begin
    en_vec     = '0;
    {j_d, k_d} = JK_HOLD;
    if (xfer) begin
      en_vec     = mask_sel;
      {j_d, k_d} = jk_decode(cmd_sel);
`ifdef JK_BANK_CTRL_PULSE_EN
      if (cmd_sel == CMD_PULSE) {j_d, k_d} = JK_SET;
`endif
    end
`ifdef JK_BANK_CTRL_PULSE_EN
    if (state_q == ST_PULSE_HOLD && cnt_q == '0) begin
      en_vec     = mask_q;
      {j_d, k_d} = JK_CLR;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b1;
    end else if (xfer) begin
      ptr_q <= gnt1;
    end
  end

`ifdef JK_BANK_CTRL_PULSE_EN
  // busy covers only the counted extra cycles; the final CLR cycle is still not accepting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer && cmd_sel == CMD_PULSE) begin
            state_q <= ST_PULSE_HOLD;
            cnt_q   <= pulse_len;
            mask_q  <= mask_sel;
            busy_q  <= (pulse_len != '0);
          end
        end
        ST_PULSE_HOLD: begin
          if (cnt_q != '0) begin
            cnt_q  <= cnt_q - CNT_W'(1);
            busy_q <= (cnt_q != CNT_W'(1));
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (en_vec[i]),
      .j     (j_d),
      .k     (k_d),
      .q     (q[i])
    );
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb/tb_jk_bank_ctrl.sv - scoreboard bench for jk_bank_ctrl (pulse tests under JK_BANK_CTRL_PULSE_EN)
module tb_jk_bank_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [2:0]       req0_cmd, req1_cmd;
  logic [WIDTH-1:0] req0_mask, req1_mask;
  logic             req0_ready, req1_ready;
  logic [CNT_W-1:0] pulse_len;
  logic [WIDTH-1:0] q;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] exp_q_fifo[$];
  logic [WIDTH-1:0] m_q, m_pmask;
  logic [CNT_W-1:0] m_cnt;
  logic             m_last, m_ph, m_busy;
  int               hi_n, busy_n, hib;

  always #5 clk = ~clk;

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_cmd   (req0_cmd),
    .req0_mask  (req0_mask),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_cmd   (req1_cmd),
    .req1_mask  (req1_mask),
    .req1_ready (req1_ready),
    .pulse_len  (pulse_len),
    .q          (q),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check readys/busy before the edge, predict q, compare q after the edge.
  task automatic cycle();
    logic             g0, g1;
    logic [2:0]       c;
    logic [WIDTH-1:0] m, nq;
    @(negedge clk);
    g0 = !m_ph && req0_valid && (!req1_valid || m_last);
    g1 = !m_ph && req1_valid && (!req0_valid || !m_last);
    chk("ready0", req0_ready, g0);
    chk("ready1", req1_ready, g1);
    chk("busy", busy, m_busy);
    if (busy) busy_n++;
    if (q[hib]) hi_n++;
    nq = m_q;
    if (g0 || g1) begin
      c = g0 ? req0_cmd : req1_cmd;
      m = g0 ? req0_mask : req1_mask;
      m_last = g1;
      case (c)
        3'd1: nq = m_q & ~m;
        3'd2: nq = m_q | m;
        3'd3: nq = m_q ^ m;
        3'd4: begin
`ifdef JK_BANK_CTRL_PULSE_EN
          nq = m_q | m;
          m_ph = 1'b1;
          m_cnt = pulse_len;
          m_pmask = m;
          m_busy = (pulse_len != 0);
`endif
        end
        default: ;
      endcase
    end else if (m_ph) begin
      if (m_cnt != 0) begin
        m_cnt = m_cnt - 1;
        m_busy = (m_cnt != 0);
      end else begin
        nq = m_q & ~m_pmask;
        m_ph = 1'b0;
        m_busy = 1'b0;
      end
    end
    m_q = nq;
    exp_q_fifo.push_back(nq);
    @(posedge clk);
    #1;
    chk("q", q, exp_q_fifo.pop_front());
  endtask

  // Called 1 time unit after a rising edge; reset is asserted mid-cycle and checked at once.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    m_q = '0; m_ph = 1'b0; m_busy = 1'b0; m_cnt = '0; m_pmask = '0; m_last = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drive(input logic v0, input logic [2:0] c0, input logic [7:0] k0,
                       input logic v1, input logic [2:0] c1, input logic [7:0] k1);
    req0_valid = v0; req0_cmd = c0; req0_mask = k0;
    req1_valid = v1; req1_cmd = c1; req1_mask = k1;
  endtask

  initial begin
    reset = 1'b1;
    pulse_len = '0;
    hib = 0;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    m_q = '0; m_ph = 1'b0; m_busy = 1'b0; m_cnt = '0; m_pmask = '0; m_last = 1'b1;
    @(posedge clk);
    #1;
    // commands present during reset must be lost
    drive(1'b1, 3'd2, 8'hFF, 1'b1, 3'd3, 8'hFF);
    do_reset();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    cycle();

    drive(1'b1, 3'd2, 8'h0F, 1'b0, 3'd0, 8'h00);
    cycle();
    chk("set_0f", q, 8'h0F);

    drive(1'b1, 3'd3, 8'hFF, 1'b1, 3'd1, 8'h03);
    do_reset();
    cycle();
    chk("rr_first", q, 8'hFF);
    cycle();
    chk("rr_second", q, 8'hFC);

    for (int i = 0; i < 24; i++) begin
      drive($urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom),
            $urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom));
      pulse_len = CNT_W'($urandom_range(0, 3));
      cycle();
    end
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 20 && m_ph; i++) cycle();

`ifdef JK_BANK_CTRL_PULSE_EN
    do_reset();
    drive(1'b1, 3'd4, 8'h80, 1'b1, 3'd2, 8'h01);
    pulse_len = 4'd3;
    hib = 7; hi_n = 0; busy_n = 0;
    cycle();
    req0_valid = 1'b0;
    pulse_len = 4'd9;
    for (int i = 0; i < 4; i++) begin
      req1_mask = 8'($urandom);
      cycle();
    end
    req1_mask = 8'h01;
    cycle();
    chk("pulse3_after", q, 8'h01);
    cycle();
    chk("pulse3_high_cycles", hi_n, 4);
    chk("pulse3_busy_cycles", busy_n, 3);

    drive(1'b1, 3'd4, 8'h01, 1'b0, 3'd0, 8'h00);
    do_reset();
    pulse_len = 4'd0;
    hib = 0; hi_n = 0; busy_n = 0;
    cycle();
    req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("pulse0_high_cycles", hi_n, 1);
    chk("pulse0_busy_cycles", busy_n, 0);

    drive(1'b1, 3'd4, 8'h3C, 1'b0, 3'd0, 8'h00);
    pulse_len = 4'd5;
    cycle();
    req0_valid = 1'b0;
    cycle();
    drive(1'b1, 3'd2, 8'hFF, 1'b1, 3'd2, 8'hFF);
    do_reset();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 7; i++) cycle();
    chk("abandon_no_clr", q, 8'h00);
    drive(1'b1, 3'd2, 8'h01, 1'b1, 3'd2, 8'h02);
    cycle();
    chk("post_reset_rr", q, 8'h01);
`else
    do_reset();
    drive(1'b1, 3'd2, 8'h5A, 1'b0, 3'd0, 8'h00);
    cycle();
    drive(1'b1, 3'd4, 8'hFF, 1'b0, 3'd0, 8'h00);
    pulse_len = 4'd3;
    cycle();
    chk("cmd4_hold_q", q, 8'h5A);
    chk("cmd4_busy", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
